// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, N+1 cycles
// from the accepting edge to the done cycle; divide-by-zero resolves in one cycle.
module div_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_by_zero,
  output logic [1:0]   o_state
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [N:0]     r_rem;
  logic [N-1:0]   r_quo;
  logic [N-1:0]   r_dvs;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_r;
  logic           r_dbz;

  logic [N:0]     w_rem_sh;
  logic [N:0]     w_trial;
  logic           w_fits;
  logic [N:0]     w_rem_nxt;
  logic [N-1:0]   w_quo_nxt;
  logic           w_last;

  // One restoring step: shift {rem,quo} left, keep the difference if it did not borrow.
  assign w_rem_sh  = {r_rem[N-1:0], r_quo[N-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_dvs};
  assign w_fits    = ~w_trial[N];
  assign w_rem_nxt = w_fits ? w_trial : w_rem_sh;
  assign w_quo_nxt = {r_quo[N-2:0], w_fits};
  assign w_last    = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (B != '0) begin
              r_quo   <= A;
              r_rem   <= '0;
              r_dvs   <= B;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
              r_state <= S_RUN;
            end else begin
              // Zero divisor short-circuits straight to DONE with the saturated quotient.
              r_q     <= '1;
              r_r     <= A;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_q     <= w_quo_nxt;
            r_r     <= w_rem_nxt[N-1:0];
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;
  assign o_state     = r_state;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: random operands against an arithmetic reference (A/B, A%B)
// with a cycle-accurate expectation of busy/done/Q/R/div_by_zero.
module tb_div_seq;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         dbz;
  logic [1:0]   st;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_seq #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (a),
    .B           (b),
    .busy        (busy),
    .done        (done),
    .Q           (q),
    .R           (r),
    .div_by_zero (dbz),
    .o_state     (st)
  );

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: pending results queue plus cycles left until the next done.
  logic [2*N:0] exp_q[$];
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dbz  = 1'b0;
  logic [N-1:0] m_q    = '0;
  logic [N-1:0] m_r    = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_q    = '0;
      m_r    = '0;
      exp_q.delete();
      chk_en = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) {m_dbz, m_q, m_r} = exp_q.pop_front();
    end else if (start) begin
      if (b == '0) begin
        m_q    = '1;
        m_r    = a;
        m_dbz  = 1'b1;
        m_done = 1'b1;
      end else begin
        exp_q.push_back({1'b0, a / b, a % b});
        m_left = N;
        m_dbz  = 1'b0;
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("busy", N'(busy), N'(m_left > 0));
      chk("done", N'(done), N'(m_done));
      chk("div_by_zero", N'(dbz), N'(m_dbz));
      chk("Q", q, m_q);
      chk("R", r, m_r);
    end
  end

  // Called at a negedge; returns at the negedge one cycle after the accepting edge.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Waits (bounded) for done, optionally pulsing start mid-run; checks latency.
  task automatic wait_done(input int exp_lat, input int pulse_at);
    int lat = 1;
    while (!done && lat <= N + 4) begin
      @(negedge clk);
      lat++;
      start = (lat == pulse_at);
      if (start) begin
        a = $urandom;
        b = $urandom;
      end
    end
    start = 1'b0;
    chk("latency", N'(lat), N'(exp_lat));
  endtask

  task automatic lit(input logic [N-1:0] eq, input logic [N-1:0] er, input logic ed);
    chk("lit_Q", q, eq);
    chk("lit_R", r, er);
    chk("lit_dbz", N'(dbz), N'(ed));
    chk("lit_done", N'(done), N'(1));
  endtask

  logic [N-1:0] t_a[6] = '{32'd100, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd5, 32'd100};
  logic [N-1:0] t_b[6] = '{32'd7, 32'd1, 32'd10, 32'hFFFF_FFFF, 32'd0, 32'd7};
  logic [N-1:0] t_q[6] = '{32'd14, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd14};
  logic [N-1:0] t_r[6] = '{32'd2, 32'd0, 32'd3, 32'h8000_0000, 32'd5, 32'd2};
  logic         t_z[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", N'(busy), '0);
    chk("rst_done", N'(done), '0);
    chk("rst_Q", q, '0);
    chk("rst_R", r, '0);
    chk("rst_dbz", N'(dbz), '0);

    // Directed literal cases; the trailing 100/7 also shows div_by_zero clearing.
    for (int i = 0; i < 6; i++) begin
      issue(t_a[i], t_b[i]);
      wait_done((t_b[i] == '0) ? 1 : N + 1, 0);
      lit(t_q[i], t_r[i], t_z[i]);
      @(negedge clk);
      chk("held_Q", q, t_q[i]);
      chk("held_R", r, t_r[i]);
      chk("done_drop", N'(done), '0);
    end

    // Start mid-run is ignored; start in the DONE cycle is accepted.
    issue(32'd100, 32'd7);
    wait_done(N + 1, 11);
    lit(32'd14, 32'd2, 1'b0);
    issue(32'd9, 32'd3);
    wait_done(N + 1, 0);
    lit(32'd3, 32'd0, 1'b0);

    // Reset mid-run aborts with no done pulse.
    @(negedge clk);
    issue(32'd100, 32'd7);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", N'(busy), '0);
    chk("abort_Q", q, '0);
    chk("abort_R", r, '0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_no_done", N'(done), '0);
    end
    issue(32'd9, 32'd3);
    wait_done(N + 1, 0);
    lit(32'd3, 32'd0, 1'b0);

    // Random operands, random gaps, back-to-back starts and ignored mid-run pulses.
    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = N'($urandom_range(1, 255));
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = ra >> $urandom_range(0, 4);
      endcase
      if ($urandom_range(0, 99) == 0) rb = '0;
      if ($urandom_range(0, 2) != 0) @(negedge clk);
      issue(ra, rb);
      wait_done((rb == '0) ? 1 : N + 1,
                ($urandom_range(0, 3) == 0) ? $urandom_range(2, N) : 0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
